muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide sequencer that owns the architectural HI and LO registers of the MIPS32 core. It accepts MULT/MULTU/DIV/DIVU requests from the control path, runs a 32-step shift-add or restoring-divide sequence, and raises a stall to the core when an instruction needs HI/LO (or a new operation) before the sequence completes. It replaces the combinational HI/LO update path, so the core's ALU no longer carries multiply/divide logic.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request a new operation; sampled on the rising edge
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  32  rs operand (dividend / multiplicand)
- b  in  32  rt operand (divisor / multiplier)
- hilo_read  in  1  current instruction reads HI or LO (MFHI/MFLO)
- hi_write  in  1  MTHI: load HI from wdata
- lo_write  in  1  MTLO: load LO from wdata
- wdata  in  32  MTHI/MTLO data
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when results land in HI/LO
- stall  out  1  core must hold PC and suppress register writes this cycle

## Operation
- States: IDLE, CALC, FIX, DONE. Reset: state IDLE; hi, lo = 0; busy, done, stall = 0; iteration counter = 0.
- IDLE/DONE: start=1 latches op, a, b, and transitions to CALC with counter 0. DONE always moves to IDLE or CALC after one cycle.
- CALC: one partial-product or partial-remainder step per cycle. Counter increments; leaves after step 31 (32 cycles).
- FIX: sign correction, divide-by-zero substitution, then writes hi/lo. Next state is DONE.
- Multiply: 64-bit product; hi = product[63:32], lo = product[31:0].
- Divide: lo = quotient, hi = remainder. Signed: quotient sign = a[31]^b[31]; remainder takes sign of a (truncating division).
- Divide by zero: hi = a, lo = 32'hFFFFFFFF, for both signed and unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Signed operands are converted to magnitude on entry to CALC. Negation is applied in FIX.
- stall = busy & (start | hilo_read | hi_write | lo_write).
- start, hi_write and lo_write are ignored while busy. The core repeats the instruction under stall.
- hi_write/lo_write in IDLE or DONE update the register on the next edge. hi/lo outputs always reflect the registers, with no bypass.
- Simultaneous start and hi_write/lo_write in IDLE: the MT write takes effect. The operation result later overwrites both registers.

## Timing
- start sampled at edge 0. busy = 1 in cycles 1–33 (32 CALC cycles plus FIX). hi/lo are written at edge 34. done = 1 and busy = 0 during cycle 34.
- Back-to-back: start in the DONE cycle is accepted, and the next done comes 34 cycles later.
- Reset asserted at any edge aborts the sequence. It forces the IDLE reset values at that edge, and no done is generated.
- stall is combinational from the inputs and state. All other outputs are registered.

## Configuration
- MULDIV_SIGNED_EN defined: MULT/DIV perform the signed magnitude conversion and FIX correction as specified.
- Not defined: the sign logic is removed. op[0] is ignored, so MULT behaves as MULTU and DIV as DIVU. The overflow special case does not apply; 0x80000000 / 0xFFFFFFFF gives lo = 0, hi = 0x80000000.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Without MULDIV_SIGNED_EN -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF.
- Cycle 5 of a DIVU, assert hilo_read, then start with new operands -> stall=1 each cycle. The second start is ignored, and results match the first operation only.
- MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle. MTLO while busy -> stall=1 and lo unchanged until done.
- Reset low at cycle 10 of a MULTU -> next cycle hi=lo=0, busy=0, and no done pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// muldiv_unit
// Iterative multiply/divide sequencer that owns the architectural HI/LO
// registers. MULT/MULTU run a 32-step shift-add. DIV/DIVU run a 32-step
// restoring divide. The core is stalled while a sequence is in flight and it
// needs HI/LO or the unit.
//
// Configuration macro: MULDIV_SIGNED_EN
//   defined   : MULT/DIV take operand magnitudes on entry and apply sign
//               correction in FIX.
//   undefined : op[0] is ignored, so every operation is unsigned.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-low reset
//   start/op   operation request (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   a, b       rs / rt operands
//   hilo_read  current instruction is MFHI/MFLO
//   hi_write   MTHI strobe (data on wdata)
//   lo_write   MTLO strobe (data on wdata)
//   wdata      MTHI/MTLO data
//   hi, lo     architectural HI/LO registers
//   busy       sequence in progress (CALC or FIX)
//   done       one-cycle pulse when results land in HI/LO
//   stall      combinational hold request to the core
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_read,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
  // Datapath state: no reset needed, always loaded before use.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d, a_q, a_d;
  logic               div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic               bzero_q, bzero_d;

  logic               sgn;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cneg(input logic signed [WIDTH-1:0] v,
                                            input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic signed [2*WIDTH-1:0] v,
                                               input logic n);
    return n ? -v : v;
  endfunction

  assign sgn = op[0] & SIGNED_EN;

  // Multiply step: conditional add of the multiplicand into the upper half,
  // then shift the whole {carry, upper, lower} accumulator right by one.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);

  // Restoring divide step: shift remainder:quotient left, trial-subtract the
  // divisor. The shifted remainder is WIDTH+1 bits; when it fits the divisor
  // the difference always fits back into WIDTH bits.
  assign div_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge  = div_sh >= {1'b0, m_q};
  assign div_rem = div_sh[WIDTH-1:0] - m_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    acc_d   = acc_q;
    m_d     = m_q;
    a_d     = a_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    case (state_q)
      IDLE, DONE: begin
        // MT writes win over a simultaneous start; the result overwrites later.
        if (hi_write) hi_d = wdata;
        if (lo_write) lo_d = wdata;
        state_d = IDLE;
        if (start) begin
          div_d   = op[1];
          qneg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = sgn & a[WIDTH-1];
          bzero_d = (b == '0);
          a_d     = a;
          cnt_d   = '0;
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, mag(a, sgn)};
            m_d   = mag(b, sgn);
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag(b, sgn)};
            m_d   = mag(a, sgn);
          end
          state_d = CALC;
        end
      end
      CALC: begin
        if (div_q) begin
          acc_d = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                         : {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          if (bzero_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            lo_d = cneg(acc_q[WIDTH-1:0], qneg_q);
            hi_d = cneg(acc_q[2*WIDTH-1:WIDTH], rneg_q);
          end
        end else begin
          {hi_d, lo_d} = cneg2(acc_q, qneg_q);
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    acc_q   <= acc_d;
    m_q     <= m_d;
    a_q     <= a_d;
    div_q   <= div_d;
    qneg_q  <= qneg_d;
    rneg_q  <= rneg_d;
    bzero_q <= bzero_d;
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q & (start | hilo_read | hi_write | lo_write);

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Testbench for muldiv_unit: directed operations, scoreboard of expected
// {hi,lo} results checked by an independent monitor on each done pulse.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset, start, hilo_read, hi_write, lo_write;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  typedef struct {
    string       nm;
    logic [63:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc, bcnt;

`ifdef MULDIV_SIGNED_EN
  localparam logic [63:0] E_MULT = 64'hFFFFFFFF_FFFFFFEB;
  localparam logic [63:0] E_DIV  = 64'hFFFFFFFF_FFFFFFFD;
  localparam logic [63:0] E_OVF  = 64'h00000000_80000000;
`else
  localparam logic [63:0] E_MULT = 64'h00000006_FFFFFFEB;
  localparam logic [63:0] E_DIV  = 64'h00000001_7FFFFFFC;
  localparam logic [63:0] E_OVF  = 64'h80000000_00000000;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hilo_read(hilo_read), .hi_write(hi_write), .lo_write(lo_write),
    .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected no pending result", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.nm, {hi, lo}, e.v);
      end
    end
  end

  task automatic wait_done(input string nm, input int c0, input int b0);
    cyc  = c0;
    bcnt = b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      step();
      cyc++;
    end
    check({nm, "_done_cycle"}, 64'(cyc), 64'd34);
    check({nm, "_busy_cycles"}, 64'(bcnt), 64'd33);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] e);
    exp_q.push_back('{nm, e});
    start = 1'b1; op = o; a = av; b = bv;
    step();
    start = 1'b0;
    wait_done(nm, 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; hilo_read = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) step();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    reset = 1'b1;
    step();

    // MTHI in IDLE
    hi_write = 1'b1; wdata = 32'h12345678;
    step();
    hi_write = 1'b0;
    check("mthi_idle", 64'(hi), 64'h12345678);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("mult_neg",  2'b01, 32'hFFFFFFFD, 32'd7, E_MULT);
    run_op("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2, E_DIV);
    run_op("divu_zero", 2'b10, 32'd100, 32'd0, 64'h00000064_FFFFFFFF);

    // Stall behaviour: DIVU 1000/7 with reads, a second start and MTLO mid-flight
    exp_q.push_back('{"divu_stall", 64'h00000006_0000008E});
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
    step();
    start = 1'b0;
    repeat (4) step();
    check("stall_idle_inputs", 64'(stall), 64'd0);
    check("busy_cycle5", 64'(busy), 64'd1);
    hilo_read = 1'b1;
    #1;
    check("stall_hilo_read", 64'(stall), 64'd1);
    step();
    hilo_read = 1'b0;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    #1;
    check("stall_start", 64'(stall), 64'd1);
    step();
    start = 1'b0;
    lo_write = 1'b1; wdata = 32'h0000DEAD;
    #1;
    check("stall_mtlo", 64'(stall), 64'd1);
    step();
    lo_write = 1'b0;
    check("lo_held_busy", 64'(lo), 64'hFFFFFFFF);
    wait_done("divu_stall", 8, 7);

    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, E_OVF);

    // Start with simultaneous MTLO in DONE: MT lands first, result overwrites
    exp_q.push_back('{"multu_mtlo", 64'h00000000_007FB6F6});
    start = 1'b1; op = 2'b00; a = 32'd12345; b = 32'd678;
    lo_write = 1'b1; wdata = 32'hCAFEF00D;
    step();
    start = 1'b0; lo_write = 1'b0;
    check("mtlo_with_start", 64'(lo), 64'hCAFEF00D);
    wait_done("multu_mtlo", 1, 0);

    // Reset abort at cycle 10 of a MULTU
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    step();
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    reset = 1'b1;
    repeat (40) step();
    check("abort_idle_busy", 64'(busy), 64'd0);

    run_op("multu_after_rst", 2'b00, 32'h00010000, 32'h00010000, 64'h00000001_00000000);

    repeat (3) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
